// File: rtl/slot_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : slot_manager
// Description : Scans a NUM_SLOTS code bank one slot per cycle for SAVE,
//               MATCH and DELETE, and issues the register-file write itself.
//               Optional macro SLOT_DUP_CHECK_EN: SAVE rejects duplicate codes.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_manager #(
  parameter int ADDR_W = 2,
  parameter int CODE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [CODE_W-1:0] code_in,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [CODE_W:0]   rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [CODE_W:0]   rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] hit_addr
);

  localparam int NUM_SLOTS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_SLOT = ADDR_W'(NUM_SLOTS - 1);

  localparam logic [1:0] c_OP_SAVE   = 2'b00;
  localparam logic [1:0] c_OP_MATCH  = 2'b01;
  localparam logic [1:0] c_OP_BAD    = 2'b11;

  localparam logic [1:0] c_ERR_MISS  = 2'b01;
  localparam logic [1:0] c_ERR_OP    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [CODE_W-1:0]   r_code;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [CODE_W:0]     r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [1:0]          r_err_code;
  logic [ADDR_W-1:0]   r_hit_addr;

  logic w_valid;
  logic w_code_eq;
  logic w_at_last;
  logic w_hit;

  assign w_valid   = rf_rd_data[CODE_W];
  assign w_code_eq = (rf_rd_data[CODE_W-1:0] == r_code);
  assign w_at_last = (r_rd_addr == c_LAST_SLOT);
  assign w_hit     = (r_op == c_OP_SAVE) ? !w_valid : (w_valid && w_code_eq);

`ifdef SLOT_DUP_CHECK_EN
  localparam logic [1:0] c_ERR_DUP = 2'b10;

  logic              r_dup_found;
  logic [ADDR_W-1:0] r_dup_addr;
  logic              r_free_found;
  logic [ADDR_W-1:0] r_free_addr;

  // Fold the slot currently on the bus into the running results so the
  // final decision can be made in the last scan cycle.
  logic              w_dup_any;
  logic [ADDR_W-1:0] w_dup_addr;
  logic              w_free_any;
  logic [ADDR_W-1:0] w_free_addr;

  assign w_dup_any   = r_dup_found || (w_valid && w_code_eq);
  assign w_dup_addr  = r_dup_found ? r_dup_addr : r_rd_addr;
  assign w_free_any  = r_free_found || !w_valid;
  assign w_free_addr = r_free_found ? r_free_addr : r_rd_addr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_code     <= '0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_hit_addr <= '0;
`ifdef SLOT_DUP_CHECK_EN
      r_dup_found  <= 1'b0;
      r_dup_addr   <= '0;
      r_free_found <= 1'b0;
      r_free_addr  <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op       <= op;
            r_code     <= code_in;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_hit_addr <= '0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b1;
`ifdef SLOT_DUP_CHECK_EN
            r_dup_found  <= 1'b0;
            r_free_found <= 1'b0;
`endif
            if (op == c_OP_BAD) begin
              r_error    <= 1'b1;
              r_err_code <= c_ERR_OP;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
`ifdef SLOT_DUP_CHECK_EN
          if (r_op == c_OP_SAVE) begin
            if (w_valid && w_code_eq && !r_dup_found) begin
              r_dup_found <= 1'b1;
              r_dup_addr  <= r_rd_addr;
            end
            if (!w_valid && !r_free_found) begin
              r_free_found <= 1'b1;
              r_free_addr  <= r_rd_addr;
            end
            if (w_at_last) begin
              if (w_dup_any) begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_DUP;
                r_hit_addr <= w_dup_addr;
                r_done     <= 1'b1;
                r_state    <= S_DONE;
              end else if (w_free_any) begin
                r_hit_addr <= w_free_addr;
                r_wr_en    <= 1'b1;
                r_wr_addr  <= w_free_addr;
                r_wr_data  <= {1'b1, r_code};
                r_state    <= S_COMMIT;
              end else begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_MISS;
                r_done     <= 1'b1;
                r_state    <= S_DONE;
              end
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end else
`endif
          begin
            if (w_hit) begin
              r_hit_addr <= r_rd_addr;
              if (r_op == c_OP_MATCH) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                // Write strobe is registered here so it lands in COMMIT.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_rd_addr;
                r_wr_data <= (r_op == c_OP_SAVE) ? {1'b1, r_code} : '0;
                r_state   <= S_COMMIT;
              end
            end else if (w_at_last) begin
              r_error    <= 1'b1;
              r_err_code <= c_ERR_MISS;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end

        S_COMMIT: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_rd_addr = r_rd_addr;
  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign hit_addr   = r_hit_addr;

endmodule
`default_nettype wire

// File: tb/tb_slot_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_slot_manager
// Description : Directed self-checking bench for slot_manager with a
//               behavioural four-entry register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_manager;

`ifdef SLOT_DUP_CHECK_EN
  localparam bit c_DUP = 1'b1;
`else
  localparam bit c_DUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] code_in = '0;
  logic [1:0]  rf_rd_addr;
  logic [16:0] rf_rd_data;
  logic        rf_wr_en;
  logic [1:0]  rf_wr_addr;
  logic [16:0] rf_wr_data;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [1:0]  hit_addr;

  logic [16:0] mem [4];
  logic        pl_en = 1'b0;
  logic [1:0]  pl_addr = '0;
  logic [16:0] pl_data = '0;

  int n_pass = 0;
  int n_chk  = 0;

  int          cyc, done_cyc, wr_cnt, wr_cyc;
  logic [1:0]  wr_addr_s, hit_s, ec_s;
  logic [16:0] wr_data_s;
  logic        err_s, busy_s, idle_busy;
  int          seen_done;

  always #5 clk = ~clk;

  slot_manager #(.ADDR_W(2), .CODE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .code_in    (code_in),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .hit_addr   (hit_addr)
  );

  assign rf_rd_data = mem[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    if (pl_en)    mem[pl_addr]    <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_mem(input logic [1:0] a, input logic [16:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start is sampled.
  task automatic run_op(input logic [1:0] o, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; op = o; code_in = c;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; code_in = ~c;
    cyc = 1; done_cyc = -1; wr_cnt = 0; wr_cyc = -1;
    wr_addr_s = '0; wr_data_s = '0; err_s = 1'b0; ec_s = '0; hit_s = '0; busy_s = 1'b0;
    while (done_cyc < 0 && cyc <= 20) begin
      if (rf_wr_en) begin
        wr_cnt++; wr_cyc = cyc; wr_addr_s = rf_wr_addr; wr_data_s = rf_wr_data;
      end
      if (done) begin
        done_cyc = cyc; err_s = error; ec_s = err_code; hit_s = hit_addr; busy_s = busy;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    idle_busy = busy;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 2'(i); pl_data = '0;
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_hit", hit_addr, 0);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_rd_addr", rf_rd_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // SAVE into an empty bank
    run_op(2'b00, 16'h1234);
    check("save0_wr_cnt", wr_cnt, 1);
    check("save0_wr_cyc", wr_cyc, c_DUP ? 5 : 2);
    check("save0_wr_addr", wr_addr_s, 0);
    check("save0_wr_data", wr_data_s, 17'h11234);
    check("save0_done_cyc", done_cyc, c_DUP ? 6 : 3);
    check("save0_error", err_s, 0);
    check("save0_hit", hit_s, 0);
    check("save0_busy_done", busy_s, 1);
    check("save0_idle_busy", idle_busy, 0);

    // SAVE into the only free slot, the last one
    set_mem(2'd1, 17'h11111);
    set_mem(2'd2, 17'h1ABCD);
    run_op(2'b00, 16'hBEEF);
    check("save3_wr_addr", wr_addr_s, 3);
    check("save3_wr_data", wr_data_s, 17'h1BEEF);
    check("save3_done_cyc", done_cyc, 6);
    check("save3_error", err_s, 0);
    check("save3_hit", hit_s, 3);

    // SAVE into a full bank
    run_op(2'b00, 16'h7777);
    check("full_wr_cnt", wr_cnt, 0);
    check("full_done_cyc", done_cyc, 5);
    check("full_error", err_s, 1);
    check("full_err_code", ec_s, 2'b01);
    check("full_err_held", error, 1);

    // MATCH, DELETE, MATCH-after-delete
    run_op(2'b01, 16'hABCD);
    check("match_hit", hit_s, 2);
    check("match_done_cyc", done_cyc, 4);
    check("match_wr_cnt", wr_cnt, 0);
    check("match_error", err_s, 0);
    check("match_hit_held", hit_addr, 2);

    run_op(2'b10, 16'hABCD);
    check("del_wr_cnt", wr_cnt, 1);
    check("del_wr_addr", wr_addr_s, 2);
    check("del_wr_data", wr_data_s, 17'h0);
    check("del_done_cyc", done_cyc, 5);
    check("del_mem", mem[2], 17'h0);

    run_op(2'b01, 16'hABCD);
    check("rematch_err_code", ec_s, 2'b01);
    check("rematch_error", err_s, 1);
    check("rematch_done_cyc", done_cyc, 5);
    check("rematch_wr_cnt", wr_cnt, 0);

    // Invalid slot whose data field equals the code must not match
    run_op(2'b01, 16'h0000);
    check("inv_match_err_code", ec_s, 2'b01);
    check("inv_match_done_cyc", done_cyc, 5);

    // Reserved op
    run_op(2'b11, 16'h1234);
    check("badop_done_cyc", done_cyc, 1);
    check("badop_err_code", ec_s, 2'b11);
    check("badop_error", err_s, 1);
    check("badop_wr_cnt", wr_cnt, 0);

    // Reset in the middle of a DELETE scan
    @(negedge clk);
    start = 1'b1; op = 2'b10; code_in = 16'hBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_addr", rf_rd_addr, 0);
    check("rst_mid_wr_en", rf_wr_en, 0);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || rf_wr_en) seen_done++;
    end
    check("rst_mid_no_activity", seen_done, 0);
    check("rst_mid_mem", mem[3], 17'h1BEEF);

    run_op(2'b10, 16'hBEEF);
    check("post_rst_wr_addr", wr_addr_s, 3);
    check("post_rst_done_cyc", done_cyc, 6);
    check("post_rst_error", err_s, 0);

    // Duplicate SAVE: rejected with the check, stored without it
    set_mem(2'd0, 17'h00000);
    set_mem(2'd1, 17'h15555);
    run_op(2'b00, 16'h5555);
    check("dup_err_code", ec_s, c_DUP ? 2'b10 : 2'b00);
    check("dup_error", err_s, c_DUP ? 1 : 0);
    check("dup_hit", hit_s, c_DUP ? 1 : 0);
    check("dup_wr_cnt", wr_cnt, c_DUP ? 0 : 1);
    check("dup_done_cyc", done_cyc, c_DUP ? 5 : 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
